// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux selects, FSM states.
package mips_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_BGTZ = 6'b000111;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StRst,
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StREx,
    StRWb,
    StIEx,
    StIWb,
    StBranch,
    StJump
  } state_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/memory signal bundle for the multicycle controller.
interface multicycle_control_if;
  import mips_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            alu_zero;
  logic            alu_neg;
  logic            mem_ready;
  logic            mem_req;
  logic            mem_write;
  logic            iord;
  logic            ir_write;
  logic            pc_en;
  logic [1:0]      pc_source;
  logic [1:0]      alu_op;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            instr_done;
  logic            illegal_op;

  modport master (
    input  opcode, alu_zero, alu_neg, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_en, pc_source, alu_op, alu_src_a,
           alu_src_b, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op
  );

  modport slave (
    output opcode, alu_zero, alu_neg, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_en, pc_source, alu_op, alu_src_a,
           alu_src_b, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op
  );
endinterface

// File: rtl/branch_cond.sv
// Branch-taken decision from the captured opcode and ALU flags.
module branch_cond
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  input  logic            alu_zero_i,
  input  logic            alu_neg_i,
  output logic            taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OP_BEQ:  taken_o = alu_zero_i;
      OP_BNE:  taken_o = ~alu_zero_i;
      // rt is $0, so the ALU result is rs itself
      OP_BGTZ: taken_o = ~alu_zero_i & ~alu_neg_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
module multicycle_control
  import mips_pkg::*;
(
  input logic                 clk,
  input logic                 reset_n,
  multicycle_control_if.master bus
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] opcode_q;
  logic            taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRst;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) opcode_q <= bus.opcode;
    end
  end

  branch_cond u_branch_cond (
    .opcode_i   (opcode_q),
    .alu_zero_i (bus.alu_zero),
    .alu_neg_i  (bus.alu_neg),
    .taken_o    (taken)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:     state_d = StFetch;
      StFetch:   if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OP_LW, OP_SW:              state_d = StMemAddr;
          OP_R:                      state_d = StREx;
          OP_ADDI:                   state_d = StIEx;
          OP_BEQ, OP_BNE, OP_BGTZ:   state_d = StBranch;
          OP_J:                      state_d = StJump;
          default:                   state_d = StFetch;
        endcase
      end
      StMemAddr: state_d = (opcode_q == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWr:   if (bus.mem_ready) state_d = StFetch;
      StREx:     state_d = StRWb;
      StIEx:     state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
      default:   state_d = StRst;
    endcase
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_source  = PC_SRC_ALU;
    bus.alu_op     = ALU_ADD;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRC_B_REG;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = SRC_B_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
      end
      StDecode: begin
        bus.alu_src_b = SRC_B_IMM_SH;
        case (bus.opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ, OP_ADDI, OP_J: ;
          default: begin
            bus.illegal_op = 1'b1;
            bus.instr_done = 1'b1;
          end
        endcase
      end
      StMemAddr, StIEx: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
      end
      StMemRd: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      StMemWr: begin
        bus.mem_req    = 1'b1;
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      StREx: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
      end
      StRWb: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      StIWb: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      StBranch: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_op     = ALU_SUB;
        bus.pc_source  = PC_SRC_ALUOUT;
        bus.pc_en      = taken;
        bus.instr_done = 1'b1;
      end
      StJump: begin
        bus.pc_source  = PC_SRC_JUMP;
        bus.pc_en      = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle bench for multicycle_control; every output compared as one packed word.
module tb_multicycle_control;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req,mem_write,iord,ir_write,pc_en}_{pc_source}_{alu_op}_{src_a}_{src_b}_
  // {reg_write,reg_dst,mem_to_reg,instr_done,illegal_op}
  logic [16:0] outs;
  assign outs = {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_en, bus.pc_source,
                 bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.reg_dst,
                 bus.mem_to_reg, bus.instr_done, bus.illegal_op};

  localparam logic [16:0] O_ZERO   = 17'b00000_00_00_0_00_00000;
  localparam logic [16:0] FETCH_W  = 17'b10000_00_00_0_01_00000;
  localparam logic [16:0] FETCH_R  = 17'b10011_00_00_0_01_00000;
  localparam logic [16:0] DECODE   = 17'b00000_00_00_0_11_00000;
  localparam logic [16:0] DEC_ILL  = 17'b00000_00_00_0_11_00011;
  localparam logic [16:0] MEM_ADDR = 17'b00000_00_00_1_10_00000;
  localparam logic [16:0] MEM_RD   = 17'b10100_00_00_0_00_00000;
  localparam logic [16:0] MEM_WB   = 17'b00000_00_00_0_00_10110;
  localparam logic [16:0] MEM_WR_W = 17'b11100_00_00_0_00_00000;
  localparam logic [16:0] MEM_WR_R = 17'b11100_00_00_0_00_00010;
  localparam logic [16:0] R_EX     = 17'b00000_00_10_1_00_00000;
  localparam logic [16:0] R_WB     = 17'b00000_00_00_0_00_11010;
  localparam logic [16:0] I_EX     = 17'b00000_00_00_1_10_00000;
  localparam logic [16:0] I_WB     = 17'b00000_00_00_0_00_10010;
  localparam logic [16:0] BR_NT    = 17'b00000_01_01_1_00_00010;
  localparam logic [16:0] BR_T     = 17'b00001_01_01_1_00_00010;
  localparam logic [16:0] JUMP     = 17'b00001_10_00_0_00_00010;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs sampled on the falling edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    @(negedge clk);
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    bus.opcode    = 6'b000000;
    bus.alu_zero  = 1'b0;
    bus.alu_neg   = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_held", O_ZERO);
    reset_n = 1'b1;
    cyc("rst_state", O_ZERO);

    // R-type, zero wait: done on cycle 4
    cyc("r_fetch", FETCH_R);
    bus.opcode = 6'b000000;
    cyc("r_decode", DECODE);
    cyc("r_ex", R_EX);
    cyc("r_wb", R_WB);

    // lw with 2 FETCH waits and 3 MEM_RD waits: 10 cycles
    bus.mem_ready = 1'b0;
    cyc("lw_fetch_w0", FETCH_W);
    cyc("lw_fetch_w1", FETCH_W);
    bus.mem_ready = 1'b1;
    cyc("lw_fetch_r", FETCH_R);
    bus.opcode    = 6'b100011;
    bus.mem_ready = 1'b0;
    cyc("lw_decode", DECODE);
    bus.opcode = 6'b000000;  // captured copy must steer MEM_ADDR
    cyc("lw_addr", MEM_ADDR);
    cyc("lw_rd_w0", MEM_RD);
    cyc("lw_rd_w1", MEM_RD);
    cyc("lw_rd_w2", MEM_RD);
    bus.mem_ready = 1'b1;
    cyc("lw_rd_r", MEM_RD);
    cyc("lw_wb", MEM_WB);

    // sw with one MEM_WR wait
    cyc("sw_fetch", FETCH_R);
    bus.opcode = 6'b101011;
    cyc("sw_decode", DECODE);
    bus.mem_ready = 1'b0;
    cyc("sw_addr", MEM_ADDR);
    cyc("sw_wr_w", MEM_WR_W);
    bus.mem_ready = 1'b1;
    cyc("sw_wr_r", MEM_WR_R);

    // addi
    cyc("addi_fetch", FETCH_R);
    bus.opcode = 6'b001000;
    cyc("addi_decode", DECODE);
    cyc("addi_ex", I_EX);
    cyc("addi_wb", I_WB);

    // beq taken; IR change after DECODE must not matter
    cyc("beq_fetch", FETCH_R);
    bus.opcode = 6'b000100;
    cyc("beq_decode", DECODE);
    bus.opcode   = 6'b000101;
    bus.alu_zero = 1'b1;
    cyc("beq_taken", BR_T);

    // bne with zero: not taken
    cyc("bne_fetch", FETCH_R);
    bus.opcode = 6'b000101;
    cyc("bne_decode", DECODE);
    bus.alu_zero = 1'b1;
    cyc("bne_not_taken", BR_NT);

    // bgtz negative: not taken
    cyc("bgtz_fetch0", FETCH_R);
    bus.opcode = 6'b000111;
    cyc("bgtz_decode0", DECODE);
    bus.alu_zero = 1'b0;
    bus.alu_neg  = 1'b1;
    cyc("bgtz_neg", BR_NT);

    // bgtz positive: taken
    cyc("bgtz_fetch1", FETCH_R);
    cyc("bgtz_decode1", DECODE);
    bus.alu_neg = 1'b0;
    cyc("bgtz_pos", BR_T);

    // jump
    cyc("j_fetch", FETCH_R);
    bus.opcode = 6'b000010;
    cyc("j_decode", DECODE);
    cyc("j_jump", JUMP);

    // illegal opcode: 2-cycle instruction
    cyc("ill_fetch", FETCH_R);
    bus.opcode = 6'b111111;
    cyc("ill_decode", DEC_ILL);
    cyc("ill_back_fetch", FETCH_R);

    // asynchronous reset while a read is outstanding
    bus.opcode = 6'b100011;
    cyc("lw2_decode", DECODE);
    bus.mem_ready = 1'b0;
    cyc("lw2_addr", MEM_ADDR);
    cyc("lw2_rd_w", MEM_RD);
    @(negedge clk);
    check("pre_reset_rd", outs, MEM_RD);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs, O_ZERO);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("rst_after_release", O_ZERO);
    cyc("fetch_after_release", FETCH_W);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
